ddc_i2c_target: RTL and testbench



---
 rtl/ddc_pkg.sv | 31 +++
 rtl/i2c_line_filter.sv | 51 +++++
 rtl/ddc_i2c_target.sv | 179 +++++++++++++++++
 tb/tb_ddc_i2c_target.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC/EDID I2C target.
// Contents:
//   ddc_state_t   - protocol FSM states
//   DDC_DEV_ADDR  - default 7-bit device address (EDID)
//   ACK / NACK    - SDA levels of the acknowledge bit
//   addr_match    - device-address compare; a general call never matches
package ddc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADR,
    ST_ACK_DEV,
    ST_WR_OFS,
    ST_ACK_OFS,
    ST_WR_DATA,
    ST_ACK_DATA,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } ddc_state_t;

  localparam logic [6:0] DDC_DEV_ADDR = 7'h50;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  function automatic logic addr_match(input logic [6:0] rx_addr,
                                      input logic [6:0] dev_addr);
    return (rx_addr == dev_addr) && (rx_addr != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditioning for one raw open-drain I2C line.
// A 2-flop synchronizer feeds a majority-free glitch filter: the accepted
// level only changes after FILTER_LEN consecutive identical synchronized
// samples. Pin-to-level latency is 2 + FILTER_LEN clocks.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (line idles high)
//   pin       - raw asynchronous pin level
//   level     - filtered line level
//   rise/fall - one-cycle pulses on filtered level changes
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]            sync_reg;
  logic [FILTER_LEN-2:0] hist_reg;
  logic [FILTER_LEN-1:0] window;
  logic                  level_reg;
  logic                  level_prev_reg;

  // Newest synchronized sample plus the FILTER_LEN-1 before it.
  assign window = {hist_reg, sync_reg[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg       <= 2'b11;
      hist_reg       <= '1;
      level_reg      <= 1'b1;
      level_prev_reg <= 1'b1;
    end else begin
      sync_reg       <= {sync_reg[0], pin};
      hist_reg       <= window[FILTER_LEN-2:0];
      level_prev_reg <= level_reg;
      if (&window)
        level_reg <= 1'b1;
      else if (~|window)
        level_reg <= 1'b0;
    end
  end

  assign level = level_reg;
  assign rise  = level_reg & ~level_prev_reg;
  assign fall  = ~level_reg & level_prev_reg;

endmodule

// File: rtl/ddc_i2c_target.sv
// DDC/EDID I2C target: decodes START/STOP, device address, offset and data
// bytes, ACKs its own address, forwards writes to and prefetches reads from
// an external byte memory (registered read, data 1 cycle after oRD_EN).
// Ports:
//   iCLK, iRESET        - clock, asynchronous active-high reset
//   iSCL, iSDA          - raw pin levels
//   oSDA_OE             - 1 = pull SDA low
//   oRD_EN, iRD_DATA    - memory read strobe / data
//   oWR_EN, oWR_DATA    - memory write strobe / data
//   oADDR               - offset pointer, used as memory address
//   oBUSY               - addressed transaction in progress
module ddc_i2c_target
  import ddc_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DDC_DEV_ADDR,
  parameter int         FILTER_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  output logic       oRD_EN,
  output logic [7:0] oADDR,
  input  logic [7:0] iRD_DATA,
  output logic       oWR_EN,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start, stop;

  ddc_state_t state_reg, state_next;
  logic [7:0] shreg_reg, ptr_reg, wr_data_reg;
  logic [3:0] bit_cnt_reg;
  logic       rw_reg, oe_reg, rd_en_reg, rd_dly_reg, wr_en_reg, busy_reg;
  logic       oe_next, rd_en_next, wr_en_next, busy_next, load_ptr, inc_ptr;
  logic       shift_in, counting;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(iCLK), .rst(iRESET), .pin(iSCL),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(iCLK), .rst(iRESET), .pin(iSDA),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl_level;
  assign stop  = sda_rise & scl_level;

  assign shift_in = ((state_reg == ST_DEVADR) || (state_reg == ST_WR_OFS) ||
                     (state_reg == ST_WR_DATA)) && (bit_cnt_reg < 4'd8);
  assign counting = shift_in || (state_reg == ST_RD_BYTE) || (state_reg == ST_RD_ACK);

  // State register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next state: byte boundaries are taken on the SCL fall that ends bit 8,
  // ACK slots end on the SCL fall that ends the ACK bit.
  always_comb begin
    state_next = state_reg;
    if (stop)
      state_next = ST_IDLE;
    else if (start)
      state_next = ST_DEVADR;
    else begin
      unique case (state_reg)
        ST_DEVADR:
          if (scl_fall && bit_cnt_reg == 4'd8)
            state_next = addr_match(shreg_reg[7:1], DEV_ADDR) ? ST_ACK_DEV : ST_IGNORE;
        ST_ACK_DEV:  if (scl_fall) state_next = rw_reg ? ST_RD_BYTE : ST_WR_OFS;
        ST_WR_OFS:   if (scl_fall && bit_cnt_reg == 4'd8) state_next = ST_ACK_OFS;
        ST_ACK_OFS:  if (scl_fall) state_next = ST_WR_DATA;
        ST_WR_DATA:  if (scl_fall && bit_cnt_reg == 4'd8) state_next = ST_ACK_DATA;
        ST_ACK_DATA: if (scl_fall) state_next = ST_WR_DATA;
        ST_RD_BYTE:  if (scl_fall && bit_cnt_reg == 4'd8) state_next = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda_level == NACK)
            state_next = ST_IGNORE;
          else if (scl_fall && bit_cnt_reg != 4'd0)
            state_next = ST_RD_BYTE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Outputs / datapath controls
  always_comb begin
    oe_next    = oe_reg;
    rd_en_next = 1'b0;
    wr_en_next = 1'b0;
    busy_next  = busy_reg;
    load_ptr   = 1'b0;
    inc_ptr    = wr_en_reg;
    if (start || stop) begin
      oe_next = 1'b0;
    end else if (scl_fall) begin
      // SDA only moves on the cycle after an SCL fall, based on the slot entered.
      unique case (state_next)
        ST_ACK_DEV, ST_ACK_OFS, ST_ACK_DATA: oe_next = ~ACK;
        ST_RD_BYTE:                          oe_next = ~shreg_reg[7];
        default:                             oe_next = 1'b0;
      endcase
    end
    if (stop)
      busy_next = 1'b0;
    else if (scl_fall && state_reg == ST_DEVADR && state_next == ST_ACK_DEV)
      busy_next = 1'b1;
    if (scl_fall && state_reg == ST_DEVADR && state_next == ST_ACK_DEV && shreg_reg[0])
      rd_en_next = 1'b1;
    // Master ACK/NACK slot: the pointer always advances past the byte just
    // sent; only an ACK prefetches the next one.
    if (scl_rise && state_reg == ST_RD_ACK && bit_cnt_reg == 4'd0) begin
      inc_ptr    = 1'b1;
      rd_en_next = (sda_level == ACK);
    end
    if (scl_rise && state_reg == ST_WR_DATA && bit_cnt_reg == 4'd7)
      wr_en_next = 1'b1;
    if (scl_fall && state_reg == ST_WR_OFS && state_next == ST_ACK_OFS)
      load_ptr = 1'b1;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      shreg_reg   <= 8'h00;
      ptr_reg     <= 8'h00;
      wr_data_reg <= 8'h00;
      bit_cnt_reg <= 4'd0;
      rw_reg      <= 1'b0;
      oe_reg      <= 1'b0;
      rd_en_reg   <= 1'b0;
      rd_dly_reg  <= 1'b0;
      wr_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      oe_reg     <= oe_next;
      rd_en_reg  <= rd_en_next;
      rd_dly_reg <= rd_en_reg;
      wr_en_reg  <= wr_en_next;
      busy_reg   <= busy_next;
      if (wr_en_next)
        wr_data_reg <= {shreg_reg[6:0], sda_level};
      if (load_ptr)
        ptr_reg <= shreg_reg;
      else if (inc_ptr)
        ptr_reg <= ptr_reg + 8'd1;
      if (start || state_next != state_reg)
        bit_cnt_reg <= 4'd0;
      else if (scl_rise && counting)
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      // Prefetched memory data lands well before the next SCL fall.
      if (rd_dly_reg)
        shreg_reg <= iRD_DATA;
      else if (scl_rise && shift_in)
        shreg_reg <= {shreg_reg[6:0], sda_level};
      else if (scl_rise && state_reg == ST_RD_BYTE)
        shreg_reg <= {shreg_reg[6:0], 1'b1};
      if (scl_fall && state_reg == ST_DEVADR && bit_cnt_reg == 4'd8)
        rw_reg <= shreg_reg[0];
    end
  end

  // START/STOP release SDA in the detect cycle itself.
  assign oSDA_OE  = oe_reg & ~(start | stop);
  assign oRD_EN   = rd_en_reg;
  assign oWR_EN   = wr_en_reg;
  assign oWR_DATA = wr_data_reg;
  assign oADDR    = ptr_reg;
  assign oBUSY    = busy_reg;

endmodule

// File: tb/tb_ddc_i2c_target.sv
// Directed bench for ddc_i2c_target: bit-banged I2C master, open-drain SDA,
// and a 256-byte memory model initialised to mem[i] = i ^ 8'hA5.
module tb_ddc_i2c_target;

  localparam int Q = 10;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, rd_en, wr_en, busy;
  logic [7:0] addr, rd_data, wr_data;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;
  int oe_hi_cnt = 0;
  int busy_hi_cnt = 0;
  logic [15:0] wr_q [$];

  assign sda_line = sda_m & ~sda_oe;

  ddc_i2c_target dut (
    .iCLK(clk), .iRESET(rst), .iSCL(scl_m), .iSDA(sda_line),
    .oSDA_OE(sda_oe), .oRD_EN(rd_en), .oADDR(addr), .iRD_DATA(rd_data),
    .oWR_EN(wr_en), .oWR_DATA(wr_data), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
  end

  always @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
    if (rd_en) rd_data <= mem[addr];
  end

  always @(negedge clk) begin
    if (sda_oe) oe_hi_cnt++;
    if (busy) busy_hi_cnt++;
    if (wr_en) wr_q.push_back({addr, wr_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  // glitch_bit >= 0 inserts a 2-clock SCL pulse in that bit's low phase.
  task automatic send(input string tag, input logic [7:0] b, input logic exp_ack,
                      input int glitch_bit = -1);
    logic ack;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      if (i == glitch_bit) begin
        wait_clk(4); scl_m = 1'b1; wait_clk(2); scl_m = 1'b0; wait_clk(Q - 6);
      end else begin
        wait_clk(Q);
      end
      scl_m = 1'b1; wait_clk(H);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H / 2);
    ack = sda_line;
    wait_clk(H / 2);
    scl_m = 1'b0; wait_clk(Q);
    check(tag, ack, exp_ack);
  endtask

  task automatic read_byte(input string tag, input logic master_ack, input logic [7:0] exp);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(H / 2);
      d[i] = sda_line;
      wait_clk(H / 2);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = master_ack; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
    check(tag, d, exp);
  endtask

  initial begin
    int oe0, busy0, wq0;

    // Reset state
    wait_clk(5);
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst rd_en", rd_en, 1'b0);
    check("rst wr_en", wr_en, 1'b0);
    check("rst addr", addr, 8'h00);
    check("rst wr_data", wr_data, 8'h00);
    check("rst busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(10);
    $display("txn0 reset checked");

    // Offset write 0x10, repeated START, read 3 bytes
    i2c_start();
    send("t1 dev w ack", 8'hA0, 1'b0);
    send("t1 ofs ack", 8'h10, 1'b0);
    i2c_start();
    send("t1 dev r ack", 8'hA1, 1'b0);
    check("t1 busy", busy, 1'b1);
    read_byte("t1 rd 0x10", 1'b0, 8'hB5);
    read_byte("t1 rd 0x11", 1'b0, 8'hB4);
    read_byte("t1 rd 0x12", 1'b1, 8'hB7);
    i2c_stop();
    check("t1 ptr", addr, 8'h13);
    check("t1 busy after stop", busy, 1'b0);
    $display("txn1 ofs 0x10 read 3 bytes, ptr 0x%0h", addr);

    // Foreign address 0x51 and general call: never ACKed, never driven
    oe0 = oe_hi_cnt; busy0 = busy_hi_cnt;
    i2c_start();
    send("t2 dev 0x51 nack", 8'hA2, 1'b1);
    send("t2 byte ignored", 8'h00, 1'b1);
    i2c_stop();
    i2c_start();
    send("t2 general call nack", 8'h00, 1'b1);
    i2c_stop();
    check("t2 sda_oe never high", 16'(oe_hi_cnt - oe0), 16'd0);
    check("t2 busy never high", 16'(busy_hi_cnt - busy0), 16'd0);
    check("t2 ptr kept", addr, 8'h13);
    $display("txn2 addr 0x51 and 0x00 ignored");

    // Pointer wrap
    i2c_start();
    send("t3 dev w ack", 8'hA0, 1'b0);
    send("t3 ofs ack", 8'hFE, 1'b0);
    i2c_start();
    send("t3 dev r ack", 8'hA1, 1'b0);
    read_byte("t3 rd 0xFE", 1'b0, 8'h5B);
    read_byte("t3 rd 0xFF", 1'b0, 8'h5A);
    read_byte("t3 rd 0x00", 1'b1, 8'hA5);
    i2c_stop();
    check("t3 ptr wrap", addr, 8'h01);
    $display("txn3 ofs 0xFE read 3 bytes with wrap");

    // Two-byte write at 0x20, then read back
    wq0 = wr_q.size();
    i2c_start();
    send("t4 dev w ack", 8'hA0, 1'b0);
    send("t4 ofs ack", 8'h20, 1'b0);
    send("t4 data0 ack", 8'hAA, 1'b0);
    send("t4 data1 ack", 8'h55, 1'b0);
    i2c_stop();
    check("t4 wr count", 16'(wr_q.size() - wq0), 16'd2);
    if (wr_q.size() >= wq0 + 2) begin
      check("t4 wr0 addr/data", wr_q[wq0], 16'h20AA);
      check("t4 wr1 addr/data", wr_q[wq0 + 1], 16'h2155);
    end
    check("t4 ptr", addr, 8'h22);
    i2c_start();
    send("t4 rb dev w ack", 8'hA0, 1'b0);
    send("t4 rb ofs ack", 8'h20, 1'b0);
    i2c_start();
    send("t4 rb dev r ack", 8'hA1, 1'b0);
    read_byte("t4 readback 0x20", 1'b1, 8'hAA);
    i2c_stop();
    $display("txn4 write 0x20=AA 0x21=55, readback done");

    // SCL glitch during a data byte
    wq0 = wr_q.size();
    i2c_start();
    send("t5 dev w ack", 8'hA0, 1'b0);
    send("t5 ofs ack", 8'h30, 1'b0);
    send("t5 glitched data ack", 8'h3C, 1'b0, 3);
    i2c_stop();
    check("t5 wr count", 16'(wr_q.size() - wq0), 16'd1);
    if (wr_q.size() >= wq0 + 1)
      check("t5 wr addr/data", wr_q[wq0], 16'h303C);
    $display("txn5 glitched write 0x30=3C");

    // Reset while target drives a 0 data bit (mem[0x10]=0xB5, bit 6 is 0)
    i2c_start();
    send("t6 dev w ack", 8'hA0, 1'b0);
    send("t6 ofs ack", 8'h10, 1'b0);
    i2c_start();
    send("t6 dev r ack", 8'hA1, 1'b0);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
    check("t6 driving bit6 low", sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1 check("t6 async release", sda_oe, 1'b0);
    wait_clk(3);
    scl_m = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);
    check("t6 ptr after reset", addr, 8'h00);
    check("t6 busy after reset", busy, 1'b0);
    i2c_start();
    send("t6 post dev w ack", 8'hA0, 1'b0);
    send("t6 post ofs ack", 8'h00, 1'b0);
    i2c_start();
    send("t6 post dev r ack", 8'hA1, 1'b0);
    read_byte("t6 post rd 0x00", 1'b1, 8'hA5);
    i2c_stop();
    check("t6 post ptr", addr, 8'h01);
    $display("txn6 reset mid-read, recovery read done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
